// File: rtl/frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// frame_rx_pkg
// Shared definitions for the UART frame receiver: frame-level and byte-level
// state encodings plus the default configuration constants used as parameter
// defaults by uart_frame_rx and uart_byte_rx.
// -----------------------------------------------------------------------------
package frame_rx_pkg;

  localparam int DEF_CLKS_PER_BIT    = 1085;   // Clk cycles per UART bit
  localparam int DEF_BYTES_PER_FRAME = 9216;   // bytes per image frame
  localparam int DEF_ADDR_W          = 15;     // write-address width
  localparam int DEF_TIMEOUT_CLKS    = 43400;  // idle-line limit inside a frame

  typedef enum logic [1:0] {
    F_IDLE,
    F_RECV,
    F_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 byte receiver working on an already-synchronized RX line. A start bit is
// rechecked half a bit after the falling edge; data bits (LSB first) and the
// stop bit are then sampled one full bit apart from that point.
//
// Ports
//   Clk        in   clock, rising edge
//   i_Rst_n    in   asynchronous active-low reset
//   clear      in   synchronous abort: forces B_IDLE, drops any partial byte
//   rx         in   synchronized serial line (idles high)
//   data       out  assembled byte, valid while 'valid' is high
//   valid      out  one-cycle pulse: stop bit sampled high
//   stop_err   out  one-cycle pulse: stop bit sampled low (byte discarded)
//   idle       out  FSM is in B_IDLE (waiting for a start bit)
// -----------------------------------------------------------------------------
module uart_byte_rx
  import frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       i_Rst_n,
  input  logic       clear,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       stop_err,
  output logic       idle
);

  localparam int                CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]     BIT_M1  = CW'(CLKS_PER_BIT - 1);

  byte_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          stop_wait, stop_wait_d;  // bad stop seen, waiting for RX high

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 1'b1;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    stop_wait_d = stop_wait;
    valid       = 1'b0;
    stop_err    = 1'b0;

    if (clear) begin
      state_d     = B_IDLE;
      cnt_d       = '0;
      bit_idx_d   = '0;
      stop_wait_d = 1'b0;
    end else begin
      case (state)
        B_IDLE: begin
          // The first low cycle seen here is t0; cnt counts cycles after t0.
          cnt_d     = '0;
          bit_idx_d = '0;
          if (!rx) state_d = B_START;
        end
        B_START: begin
          if (cnt == HALF_M1) begin
            cnt_d   = '0;
            state_d = rx ? B_IDLE : B_DATA;  // high at mid-start: glitch
          end
        end
        B_DATA: begin
          if (cnt == BIT_M1) begin
            cnt_d     = '0;
            shift_d   = {rx, shift[7:1]};
            bit_idx_d = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_d = B_STOP;
          end
        end
        B_STOP: begin
          if (stop_wait) begin
            cnt_d = '0;
            if (rx) begin
              state_d     = B_IDLE;
              stop_wait_d = 1'b0;
            end
          end else if (cnt == BIT_M1) begin
            cnt_d = '0;
            if (rx) begin
              valid   = 1'b1;
              state_d = B_IDLE;
            end else begin
              stop_err    = 1'b1;
              stop_wait_d = 1'b1;
            end
          end
        end
        default: state_d = B_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= B_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      stop_wait <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      stop_wait <= stop_wait_d;
    end
  end

  assign data = shift;
  assign idle = (state == B_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// Receives one image frame of BYTES_PER_FRAME bytes over a UART line and emits
// a write strobe per byte with a running byte address. A falling edge on the
// frame indicator (re)starts a frame; the frame ends after the last address
// has been written.
//
// Optional feature: define UART_FRAME_RX_TIMEOUT_EN to abort a frame (error,
// back to idle, no done pulse) when no start bit arrives for TIMEOUT_CLKS
// consecutive cycles.
//
// Ports
//   Clk                in   sole clock, rising edge
//   i_Rst_n            in   asynchronous active-low reset
//   i_RX               in   asynchronous UART line, idles high
//   i_Frame_Indicator  in   asynchronous; falling edge marks frame start
//   o_Wr_Data          out  received byte
//   o_Wr_Addr          out  byte index within the frame
//   o_Wr_En            out  one-cycle write strobe
//   o_Busy             out  high while a frame is being received
//   o_Frame_Done       out  one-cycle pulse after the last byte is written
//   o_Frame_Error      out  sticky error, cleared by a new frame start
// -----------------------------------------------------------------------------
module uart_frame_rx
  import frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
  parameter int BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int TIMEOUT_CLKS    = DEF_TIMEOUT_CLKS
) (
  input  logic              Clk,
  input  logic              i_Rst_n,
  input  logic              i_RX,
  input  logic              i_Frame_Indicator,
  output logic [7:0]        o_Wr_Data,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic              o_Wr_En,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

  logic         rx_meta, rx_sync;
  logic         ind_meta, ind_sync, ind_prev;
  logic         ind_fall;
  frame_state_t f_state, f_state_d;
  logic         byte_clear, byte_valid, byte_err, byte_idle;
  logic [7:0]   byte_data;
  logic         timeout;

  // Synchronizers reset to the idle-high level so that reset release on a
  // quiet line produces neither a start bit nor an indicator edge.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      ind_meta <= 1'b1;
      ind_sync <= 1'b1;
      ind_prev <= 1'b1;
    end else begin
      rx_meta  <= i_RX;
      rx_sync  <= rx_meta;
      ind_meta <= i_Frame_Indicator;
      ind_sync <= ind_meta;
      ind_prev <= ind_sync;
    end
  end

  assign ind_fall = ind_prev & ~ind_sync;

  // The byte receiver only runs inside a frame; a new frame start aborts it.
  assign byte_clear = (f_state != F_RECV) || ind_fall;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .Clk      (Clk),
    .i_Rst_n  (i_Rst_n),
    .clear    (byte_clear),
    .rx       (rx_sync),
    .data     (byte_data),
    .valid    (byte_valid),
    .stop_err (byte_err),
    .idle     (byte_idle)
  );

`ifdef UART_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts idle-line cycles since frame start or the last stop sample.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmo_cnt <= '0;
    end else if (f_state != F_RECV || ind_fall || byte_valid || byte_err) begin
      tmo_cnt <= '0;
    end else if (byte_idle && rx_sync) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = (f_state == F_RECV) && !ind_fall && byte_idle && rx_sync &&
                   (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
`else
  // No idle limit in this build; the tie-off keeps otherwise-unused inputs
  // of the timeout path referenced.
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CLKS, byte_idle};
  assign timeout        = 1'b0;
`endif

  always_comb begin
    f_state_d = f_state;
    case (f_state)
      F_IDLE: if (ind_fall) f_state_d = F_RECV;
      F_RECV: begin
        if (ind_fall)                                f_state_d = F_RECV;
        else if (timeout)                            f_state_d = F_IDLE;
        else if (o_Wr_En && o_Wr_Addr == LAST_ADDR)  f_state_d = F_DONE;
      end
      F_DONE:  f_state_d = ind_fall ? F_RECV : F_IDLE;
      default: f_state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) f_state <= F_IDLE;
    else          f_state <= f_state_d;
  end

  // The strobe cycle presents the current address; the address advances at
  // the end of that cycle and saturates at the last byte of the frame.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Wr_En       <= 1'b0;
      o_Wr_Data     <= '0;
      o_Wr_Addr     <= '0;
      o_Frame_Error <= 1'b0;
    end else begin
      o_Wr_En <= byte_valid;
      if (byte_valid) o_Wr_Data <= byte_data;
      if (ind_fall) begin
        o_Wr_Addr     <= '0;
        o_Frame_Error <= 1'b0;
      end else begin
        if (o_Wr_En && o_Wr_Addr != LAST_ADDR) o_Wr_Addr <= o_Wr_Addr + 1'b1;
        if (byte_err || timeout)               o_Frame_Error <= 1'b1;
      end
    end
  end

  assign o_Busy       = (f_state == F_RECV);
  assign o_Frame_Done = (f_state == F_DONE);

endmodule
